// File: rtl/mem_req_scheduler.sv
// Orders PCIe memory requests onto AXI write/read controllers so reads never pass posted writes.
// Dispatch valid rises one clock after accept; upstream ready stays low until the request retires or times out.
module mem_req_scheduler #(
  parameter int TCQ                = 1,
  parameter int MAX_WR_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_aresetn,

  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [2:0]  mem_req_bar_hit,
  input  logic [31:0] mem_req_pcie_address,
  input  logic [7:0]  mem_req_byte_enable,
  input  logic        mem_req_write_readn,
  input  logic        mem_req_phys_func,
  input  logic [63:0] mem_req_write_data,

  output logic        wr_req_valid,
  input  logic        wr_req_ready,
  output logic        rd_req_valid,
  input  logic        rd_req_ready,

  output logic [2:0]  req_bar_hit,
  output logic [31:0] req_pcie_address,
  output logic [7:0]  req_byte_enable,
  output logic        req_phys_func,
  output logic [63:0] req_write_data,

  input  logic        wr_done,
  input  logic        rd_done,
  output logic [3:0]  wr_outstanding,
  output logic        wr_timeout,
  output logic        rd_timeout
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      WR_CAP   = 4'(MAX_WR_OUTSTANDING);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DISPATCH_WR = 3'd1,
    WAIT_DRAIN  = 3'd2,
    DISPATCH_RD = 3'd3,
    WAIT_RD     = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0]  bar_hit;
    logic [31:0] pcie_address;
    logic [7:0]  byte_enable;
    logic        phys_func;
    logic [63:0] write_data;
  } req_payload_t;

  state_t       state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]   wr_cnt_q, wr_cnt_d;
  logic         ready_q, ready_d;
  logic         wr_timeout_q, rd_timeout_q;
  logic         wr_tmo_fire, rd_tmo_fire;
  req_payload_t req_q;

  logic req_accept, wr_hs, rd_hs, wr_dec, tmo_last;

  // Registered updates are zero-delay; TCQ is accepted only for parameter compatibility.
  logic unused_tcq;
  assign unused_tcq = (TCQ != 0);

  assign req_accept   = mem_req_valid & ready_q;
  assign wr_req_valid = (state_q == DISPATCH_WR) && (wr_cnt_q < WR_CAP);
  assign rd_req_valid = (state_q == DISPATCH_RD);
  assign wr_hs        = wr_req_valid & wr_req_ready;
  assign rd_hs        = rd_req_valid & rd_req_ready;
  assign wr_dec       = wr_done && (wr_cnt_q != 4'd0);
  assign tmo_last     = (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    wr_tmo_fire = 1'b0;
    rd_tmo_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_accept) begin
          if (mem_req_write_readn)    state_d = DISPATCH_WR;
          else if (wr_cnt_q == 4'd0)  state_d = DISPATCH_RD;
          else                        state_d = WAIT_DRAIN;
        end
      end
      DISPATCH_WR: begin
        if (wr_hs) state_d = IDLE;
      end
      WAIT_DRAIN: begin
        // A write response in the final cycle counts as progress and restarts the wait.
        if (wr_cnt_q == 4'd0) begin
          state_d = DISPATCH_RD;
        end else if (!wr_done && tmo_last) begin
          wr_tmo_fire = 1'b1;
          state_d     = DISPATCH_RD;
        end
      end
      DISPATCH_RD: begin
        if (rd_hs) state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (rd_done) begin
          state_d = IDLE;
        end else if (tmo_last) begin
          rd_tmo_fire = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tmo_cnt_d = '0;
    if ((state_d == WAIT_DRAIN || state_d == WAIT_RD) && (state_d == state_q)) begin
      if (!(state_q == WAIT_DRAIN && wr_done)) tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_tmo_fire)           wr_cnt_d = 4'd0;
    else if (wr_hs && !wr_dec) wr_cnt_d = wr_cnt_q + 4'd1;
    else if (!wr_hs && wr_dec) wr_cnt_d = wr_cnt_q - 4'd1;
  end

  // Ready only after a full cycle in IDLE, which also spaces accepts at least two clocks apart.
  assign ready_d = (state_q == IDLE) && (state_d == IDLE);

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q      <= IDLE;
      tmo_cnt_q    <= '0;
      wr_cnt_q     <= 4'd0;
      ready_q      <= 1'b0;
      wr_timeout_q <= 1'b0;
      rd_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      ready_q      <= ready_d;
      wr_timeout_q <= wr_tmo_fire;
      rd_timeout_q <= rd_tmo_fire;
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (req_accept) begin
      req_q <= {mem_req_bar_hit, mem_req_pcie_address, mem_req_byte_enable,
                mem_req_phys_func, mem_req_write_data};
    end
  end

  assign mem_req_ready    = ready_q;
  assign wr_outstanding   = wr_cnt_q;
  assign wr_timeout       = wr_timeout_q;
  assign rd_timeout       = rd_timeout_q;
  assign req_bar_hit      = req_q.bar_hit;
  assign req_pcie_address = req_q.pcie_address;
  assign req_byte_enable  = req_q.byte_enable;
  assign req_phys_func    = req_q.phys_func;
  assign req_write_data   = req_q.write_data;

endmodule
